axis_i2s_tx: RTL and testbench

// - AXI-Stream sink that turns stereo 2-word packets (left word, then right word with last=1) into an
//   I2S serial stream for the Pmod I2S2 DAC. Sits downstream of the volume controller.
// - Generates LRCK/SCLK from a free-running frame counter. MCLK is the block clock, forwarded at top level.
// - One frame buffer (pending pair) is loaded into the output shift registers on each frame boundary.

---
 rtl/axis_i2s_tx.sv | 114 +++++++++++
 tb/tb_axis_i2s_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2s_tx.sv
// AXI-Stream stereo sink that serialises left/right sample pairs into an I2S stream for the Pmod I2S2 DAC.
// Define AXIS_I2S_TX_HOLD_EN to repeat the last frame on underrun instead of sending silence.
module axis_i2s_tx #(
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic                  tx_lrck,
  output logic                  tx_sclk,
  output logic                  tx_sdout,
  output logic                  underrun,
  output logic                  pair_err
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned PAD    = 31 - DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next_c;
  logic [SLOT_W-1:0]     slot_next_c;
  logic [DATA_WIDTH-1:0] left_buf;
  logic [DATA_WIDTH-1:0] right_buf;
  logic [DATA_WIDTH-1:0] sh_l;
  logic [DATA_WIDTH-1:0] sh_r;
  logic                  left_ok;
  logic                  pair_full;
  logic                  frame_end_c;
  logic                  accept_c;
  logic                  sd_bit_c;
  logic [31:0]           slot_word_c;

  // Ready drops on the load cycle so an accept never races the frame load.
  assign frame_end_c  = (cnt == CNT_LAST);
  assign s_axis_ready = ~pair_full & ~frame_end_c;
  assign accept_c     = s_axis_valid & s_axis_ready;

  assign cnt_next_c  = cnt + CNT_W'(1);
  assign slot_next_c = cnt_next_c[7:3];
  assign tx_lrck     = cnt[8];
  assign tx_sclk     = cnt[2];

  // Word placed as {1 delay slot, MSB..LSB, zero pad}; slot k reads bit 31-k.
  always_comb begin
    slot_word_c = 32'(cnt_next_c[8] ? sh_r : sh_l) << PAD;
    sd_bit_c    = slot_word_c[5'd31 - slot_next_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next_c;
    end
  end

  // Input pair buffer and frame-boundary load into the shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_buf  <= '0;
      right_buf <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
      left_ok   <= 1'b0;
      pair_full <= 1'b0;
    end else if (frame_end_c) begin
      pair_full <= 1'b0;
      left_ok   <= 1'b0;
      if (pair_full) begin
        sh_l <= left_buf;
        sh_r <= right_buf;
      end else begin
`ifdef AXIS_I2S_TX_HOLD_EN
        sh_l <= sh_l;
        sh_r <= sh_r;
`else
        sh_l <= '0;
        sh_r <= '0;
`endif
      end
    end else if (accept_c) begin
      if (!s_axis_last) begin
        left_buf <= s_axis_data;
        left_ok  <= 1'b1;
      end else begin
        right_buf <= s_axis_data;
        pair_full <= 1'b1;
        if (!left_ok) begin
          left_buf <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sdout <= 1'b0;
      underrun <= 1'b0;
      pair_err <= 1'b0;
    end else begin
      underrun <= frame_end_c & ~pair_full;
      pair_err <= accept_c & s_axis_last & ~left_ok;
      if (cnt[2:0] == 3'd7) begin
        tx_sdout <= sd_bit_c;
      end
    end
  end

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Scoreboard bench for axis_i2s_tx: per-frame expected words pushed by the driver, checked by a serial-stream monitor.
module tb_axis_i2s_tx;

  localparam int unsigned DW = 24;
  localparam int unsigned NF = 24;
  localparam int unsigned ND = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic          s_axis_last = 1'b0;
  logic          tx_lrck, tx_sclk, tx_sdout, underrun, pair_err;

  axis_i2s_tx #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_last(s_axis_last),
    .tx_lrck(tx_lrck), .tx_sclk(tx_sclk), .tx_sdout(tx_sdout),
    .underrun(underrun), .pair_err(pair_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            ur;
  } frame_t;

  frame_t exp_q[$];
  int     perr_q[$];
  int     checks = 0;
  int     errors = 0;
  int     ur_cnt = 0;
  int     pe_cnt = 0;
  int     frames_seen = 0;
  logic   mon_en = 1'b1;
  logic [8:0] tcnt;

`ifdef AXIS_I2S_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Clock position in the frame since reset release (time reference for the driver).
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt + 9'd1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (underrun) ur_cnt <= ur_cnt + 1;
      if (pair_err) pe_cnt <= pe_cnt + 1;
      if (mon_en && tcnt == 9'd511) chk("ready_at_511", 32'(s_axis_ready), 32'd0);
    end
  end

  // Monitor: rebuild each frame from the bit clock and compare against the scoreboard.
  initial begin
    logic [31:0] cl, cr, el, er;
    int b, ur_prev, pe_prev, pe_exp;
    bit lr_ok;
    frame_t e;
    b = 0; ur_prev = 0; pe_prev = 0; lr_ok = 1'b1; cl = '0; cr = '0;
    wait (!rst);
    forever begin
      @(posedge tx_sclk);
      #1;
      if (!mon_en) continue;
      if (b < 32) begin
        cl = {cl[30:0], tx_sdout};
        if (tx_lrck !== 1'b0) lr_ok = 1'b0;
      end else begin
        cr = {cr[30:0], tx_sdout};
        if (tx_lrck !== 1'b1) lr_ok = 1'b0;
      end
      b++;
      if (b == 64) begin
        b = 0;
        chk("lrck_phase", 32'(lr_ok), 32'd1);
        lr_ok = 1'b1;
        if (exp_q.size() == 0 || perr_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          pe_exp = perr_q.pop_front();
          el = 32'(e.l) << (31 - DW);
          er = 32'(e.r) << (31 - DW);
          chk($sformatf("left_f%0d", frames_seen), cl, el);
          chk($sformatf("right_f%0d", frames_seen), cr, er);
          chk($sformatf("underrun_f%0d", frames_seen), 32'(ur_cnt - ur_prev), 32'(e.ur));
          chk($sformatf("pair_err_f%0d", frames_seen), 32'(pe_cnt - pe_prev), 32'(pe_exp));
        end
        ur_prev = ur_cnt;
        pe_prev = pe_cnt;
        frames_seen++;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    chk("ready_offer", 32'(s_axis_ready), 32'd1);
    n = 0;
    while (!s_axis_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) chk("handshake_timeout", 32'd1, 32'd0);
    @(negedge clk);
    s_axis_valid = 1'b0;
    if (l) chk("ready_after_right", 32'(s_axis_ready), 32'd0);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic wait_pos(input logic [8:0] p);
    int n;
    n = 0;
    while (tcnt != p && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n == 600) chk("wait_pos_timeout", 32'd1, 32'd0);
  endtask

  // Driver: one scenario per frame; expectation for the next frame pushed immediately.
  initial begin
    int sc_tab[ND] = '{1, 1, 0, 0, 2, 3};
    logic [DW-1:0] a_tab[ND] = '{24'h7FFFFF, 24'h123456, 24'h0, 24'h0, 24'h00000F, 24'h000001};
    logic [DW-1:0] b_tab[ND] = '{24'h800000, 24'h654321, 24'h0, 24'h0, 24'h0,      24'h000002};
    logic [DW-1:0] c_tab[ND] = '{24'h0,      24'h0,      24'h0, 24'h0, 24'h0,      24'h000003};
    logic [DW-1:0] wa, wb, wc, lv, rv, prev_l, prev_r;
    logic have_l, have_r;
    frame_t e;
    int sc, start, n;

    prev_l = '0; prev_r = '0;
    e.l = '0; e.r = '0; e.ur = 0;
    exp_q.push_back(e);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < int'(NF); f++) begin
      if (f < int'(ND)) begin
        sc = sc_tab[f]; wa = a_tab[f]; wb = b_tab[f]; wc = c_tab[f];
        start = (f == 0) ? 10 : int'($urandom_range(1, 300));
      end else begin
        sc = int'($urandom_range(0, 4));
        wa = DW'($urandom); wb = DW'($urandom); wc = DW'($urandom);
        start = int'($urandom_range(1, 300));
      end
      if (f > 0) wait_pos(9'd511);
      wait_pos(9'(start));
      have_l = 1'b0; have_r = 1'b0; lv = '0; rv = '0;
      case (sc)
        1: begin send(wa, 1'b0); gap(); send(wb, 1'b1);
                 have_l = 1'b1; lv = wa; have_r = 1'b1; rv = wb; end
        2: begin send(wa, 1'b1); have_r = 1'b1; rv = wa; end
        3: begin send(wa, 1'b0); gap(); send(wb, 1'b0); gap(); send(wc, 1'b1);
                 have_l = 1'b1; lv = wb; have_r = 1'b1; rv = wc; end
        4: begin send(wa, 1'b0); have_l = 1'b1; lv = wa; end
        default: ;
      endcase
      if (have_r) begin
        e.l = have_l ? lv : '0; e.r = rv; e.ur = 0;
      end else begin
        e.l = HOLD ? prev_l : '0; e.r = HOLD ? prev_r : '0; e.ur = 1;
      end
      prev_l = e.l; prev_r = e.r;
      exp_q.push_back(e);
      perr_q.push_back((have_r && !have_l) ? 1 : 0);
    end
    perr_q.push_back(0);

    n = 0;
    while (frames_seen < int'(NF) + 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frames_seen", 32'(frames_seen), 32'(NF + 1));
    mon_en = 1'b0;

    // Mid-frame reset: outputs clear asynchronously and the frame counter restarts.
    wait_pos(9'd300);
    chk("lrck_before_rst", 32'(tx_lrck), 32'd1);
    chk("sclk_before_rst", 32'(tx_sclk), 32'd1);
    rst = 1'b1;
    #1;
    chk("lrck_in_rst", 32'(tx_lrck), 32'd0);
    chk("sclk_in_rst", 32'(tx_sclk), 32'd0);
    chk("sdout_in_rst", 32'(tx_sdout), 32'd0);
    chk("ready_in_rst", 32'(s_axis_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("lrck_restart_%0d", i), 32'(tx_lrck), 32'd0);
      chk($sformatf("sclk_restart_%0d", i), 32'(tx_sclk), 32'((i >> 2) & 1));
      chk($sformatf("sdout_restart_%0d", i), 32'(tx_sdout), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
